// File: rtl/matmul_apb_pkg.sv
// rtl/matmul_apb_pkg.sv - shared state encoding, register map and control-word layout for the matmul APB initiator
package matmul_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Register map of the accelerator's APB slave (word indices)
    localparam int unsigned CTRL_ADDR = 0;
    localparam int unsigned A_BASE    = 4;
    localparam int unsigned B_BASE    = 8;
    localparam int unsigned RES_BASE  = 16;

    // Control-word field positions
    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_BIAS_BIT   = 1;
    localparam int unsigned CTRL_SP_ROW_LSB = 2;
    localparam int unsigned CTRL_SP_SEL_LSB = 4;
    localparam int unsigned CTRL_N_LSB      = 8;
    localparam int unsigned CTRL_K_LSB      = 10;
    localparam int unsigned CTRL_M_LSB      = 12;

    // Assemble a control word from its fields; unused bits are zero
    function automatic logic [31:0] make_ctrl(
        input logic       start,
        input logic       bias,
        input logic [1:0] sp_row,
        input logic [1:0] sp_sel,
        input logic [1:0] n,
        input logic [1:0] k,
        input logic [1:0] m
    );
        logic [31:0] word;
        word = '0;
        word[CTRL_START_BIT]         = start;
        word[CTRL_BIAS_BIT]          = bias;
        word[CTRL_SP_ROW_LSB +: 2]   = sp_row;
        word[CTRL_SP_SEL_LSB +: 2]   = sp_sel;
        word[CTRL_N_LSB +: 2]        = n;
        word[CTRL_K_LSB +: 2]        = k;
        word[CTRL_M_LSB +: 2]        = m;
        return word;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - ACCESS-phase wait counter, built only with MATMUL_APB_MASTER_TIMEOUT_EN
`ifdef MATMUL_APB_MASTER_TIMEOUT_EN
module apb_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Count stalled cycles; saturate on the last one so expiry stays asserted
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    // Expired during the LIMIT-th consecutive stalled cycle
    assign expired = (count == LAST);

endmodule
`endif

// File: rtl/matmul_apb_master.sv
// rtl/matmul_apb_master.sv - APB4 initiator turning cmd/rsp handshakes into single transfers; option MATMUL_APB_MASTER_TIMEOUT_EN
module matmul_apb_master
    import matmul_apb_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,

    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,

    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,

    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    output logic [BUS_WIDTH-1:0]            pwdata_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
    input  logic [BUS_WIDTH-1:0]            prdata_i,
    input  logic                            pready_i,
    input  logic                            pslverr_i
);
    localparam int STRB_WIDTH = BUS_WIDTH / DATA_WIDTH;

    // Reject configurations that cannot work at elaboration time
    if ((TIMEOUT_CYCLES < 1) || (BUS_WIDTH % DATA_WIDTH != 0)) begin : g_bad_config
        $error("matmul_apb_master: TIMEOUT_CYCLES must be >= 1 and BUS_WIDTH a multiple of DATA_WIDTH");
    end

    apb_state_e  state;
    logic [15:0] xfer_count;
    logic        timeout_hit;

`ifdef MATMUL_APB_MASTER_TIMEOUT_EN
    logic timeout_expired;

    apb_timeout_counter #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state != ST_ACCESS),
        .enable  ((state == ST_ACCESS) && !pready_i),
        .expired (timeout_expired)
    );

    // Abort only when still stalled; a pready in the expiry cycle completes normally
    assign timeout_hit = (state == ST_ACCESS) && !pready_i && timeout_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            xfer_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        psel_o      <= 1'b1;
                        pwrite_o    <= cmd_write_i;
                        paddr_o     <= cmd_addr_i;
                        if (cmd_write_i) begin
                            pwdata_o <= cmd_wdata_i;
                            pstrb_o  <= cmd_strb_i;
                        end else begin
                            pstrb_o  <= STRB_WIDTH'(0);
                        end
                        state <= ST_SETUP;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (pready_i) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o   <= pslverr_i;
                        rsp_valid_o <= 1'b1;
                        xfer_count  <= xfer_count + 16'd1;
                        state       <= ST_RESP;
                    end else if (timeout_hit) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_apb_master.sv
// tb/tb_matmul_apb_master.sv - self-checking bench for matmul_apb_master (honours MATMUL_APB_MASTER_TIMEOUT_EN)
module tb_matmul_apb_master;
    import matmul_apb_pkg::*;

    localparam int BW = 32;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int TO = 16;
    localparam int SW = BW / DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [BW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [BW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int checks   = 0;
    int failures = 0;

    // Reference state: last written data on the bus and completed transfers since reset
    logic [BW-1:0] model_pwdata;
    int            model_count;

    always #5 clk = ~clk;

    matmul_apb_master #(
        .BUS_WIDTH      (BW),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_write_i (cmd_write),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_strb_i  (cmd_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic sel, input logic en, input logic [AW-1:0] addr,
                             input logic wr, input logic [SW-1:0] strb, input logic [BW-1:0] wdata);
        check({tag, "_psel"},    32'(psel),    32'(sel));
        check({tag, "_penable"}, 32'(penable), 32'(en));
        check({tag, "_paddr"},   32'(paddr),   32'(addr));
        check({tag, "_pwrite"},  32'(pwrite),  32'(wr));
        check({tag, "_pstrb"},   32'(pstrb),   32'(strb));
        check({tag, "_pwdata"},  pwdata,       wdata);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        pready = 1'b0;
        step();
        model_pwdata = '0;
        model_count  = 0;
    endtask

    // One complete transfer: slave inserts 'waits' stall cycles, host stalls the response 'rsp_delay' cycles
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                           input logic [SW-1:0] strb, input int waits, input logic err,
                           input logic [BW-1:0] rdata, input int rsp_delay, input logic hold_junk);
        logic [SW-1:0] e_strb;
        logic [BW-1:0] e_rdata;
        int            guard;
        e_strb  = wr ? strb : '0;
        e_rdata = wr ? '0 : rdata;
        if (wr) model_pwdata = wdata;
        guard = 0;
        while (!cmd_ready && guard < 8) begin
            step();
            guard++;
        end
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        step();
        if (hold_junk) begin
            cmd_write = ~wr;
            cmd_addr  = addr ^ 16'h00F0;
            cmd_wdata = ~wdata;
            cmd_strb  = ~strb;
        end else begin
            cmd_valid = 1'b0;
        end
        check_bus("setup", 1'b1, 1'b0, addr, wr, e_strb, model_pwdata);
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        check("setup_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        for (int i = 0; i <= waits; i++) begin
            check_bus("access", 1'b1, 1'b1, addr, wr, e_strb, model_pwdata);
            check("access_rsp_valid", 32'(rsp_valid), 32'd0);
            pready  = (i == waits);
            prdata  = pready ? rdata : $urandom;
            pslverr = pready ? err : 1'($urandom_range(0, 1));
            step();
        end
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        model_count++;
        for (int d = 0; d <= rsp_delay; d++) begin
            check("resp_valid", 32'(rsp_valid), 32'd1);
            check("resp_rdata", rsp_rdata, e_rdata);
            check("resp_err", 32'(rsp_err), 32'(err));
            check("resp_psel", 32'(psel), 32'd0);
            check("resp_penable", 32'(penable), 32'd0);
            check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
            rsp_ready = (d == rsp_delay);
            step();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_cmd_ready", 32'(cmd_ready), 32'd1);
        check("done_psel", 32'(psel), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        model_pwdata = '0;
        model_count  = 0;

        // Reset values
        step(); step(); step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_bus("rst", 1'b0, 1'b0, '0, 1'b0, '0, '0);
        rst = 1'b0;
        step();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write of an A operand word
        do_xfer(1'b1, AW'(A_BASE), 32'h04030201, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0);
        // Read of a result word with three stall cycles; strobes must be zero, junk cmd held meanwhile
        do_xfer(1'b0, AW'(RES_BASE), 32'h0, 4'h5, 3, 1'b0, 32'hAAAAAAAA, 0, 1'b1);
        // Control write answered with pslverr, then a normal read of a B word
        do_xfer(1'b1, AW'(CTRL_ADDR), 32'h0000FF01, 4'h3, 0, 1'b1, 32'h0, 0, 1'b0);
        do_xfer(1'b0, AW'(B_BASE + 1), 32'h0, 4'h0, 0, 1'b0, 32'h13579BDF, 0, 1'b0);
        // Host stalls the response five cycles
        do_xfer(1'b0, AW'(RES_BASE + 2), 32'h0, 4'h0, 1, 1'b0, 32'h5A5AC3C3, 5, 1'b1);
        // Slave answers in the last cycle before the timeout limit: normal completion either way
        do_xfer(1'b0, AW'(RES_BASE + 3), 32'h0, 4'h0, TO - 1, 1'b0, 32'hCAFEF00D, 0, 1'b0);

        // Slave never answers
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(RES_BASE); cmd_strb = '0;
        step();
        cmd_valid = 1'b0;
        step();
`ifdef MATMUL_APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            check("tmo_wait_psel", 32'(psel & penable), 32'd1);
            check("tmo_wait_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
        end
        check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        check("tmo_rsp_rdata", rsp_rdata, 32'd0);
        check("tmo_psel", 32'(psel), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("tmo_done_cmd_ready", 32'(cmd_ready), 32'd1);
`else
        for (int i = 0; i < TO + 4; i++) begin
            check("stall_psel", 32'(psel & penable), 32'd1);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
        end
        apply_reset();
        check("stall_rst_psel", 32'(psel), 32'd0);
        rst = 1'b0;
        step();
        check("stall_rst_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

        // Reset pulsed in ACCESS while the slave is completing: reset wins, no response
        do_xfer(1'b1, AW'(A_BASE + 2), 32'hDEADBEEF, 4'hC, 0, 1'b0, 32'h0, 0, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(RES_BASE + 1);
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_access_psel", 32'(psel & penable), 32'd1);
        pready = 1'b1; prdata = 32'h11112222; pslverr = 1'b1;
        rst = 1'b1;
        step();
        pready = 1'b0; pslverr = 1'b0;
        model_pwdata = '0;
        model_count  = 0;
        check("mid_rst_psel", 32'(psel), 32'd0);
        check("mid_rst_penable", 32'(penable), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_pwdata", pwdata, 32'd0);
        rst = 1'b0;
        step();
        check("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        check("after_rst_rsp_valid2", 32'(rsp_valid), 32'd0);

        // Randomised operand loads, control writes and result reads
        for (int n = 0; n < 24; n++) begin
            int            kind;
            logic [AW-1:0] a;
            logic [BW-1:0] wd;
            logic          wr;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin wr = 1'b1; a = AW'(A_BASE + $urandom_range(0, 3)); wd = $urandom; end
                1: begin wr = 1'b1; a = AW'(B_BASE + $urandom_range(0, 3)); wd = $urandom; end
                2: begin
                    wr = 1'b1; a = AW'(CTRL_ADDR);
                    wd = make_ctrl(1'b1, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom),
                                   2'($urandom), 2'($urandom), 2'($urandom));
                end
                default: begin wr = 1'b0; a = AW'(RES_BASE + $urandom_range(0, 7)); wd = $urandom; end
            endcase
            do_xfer(wr, a, wd, 4'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        check("xfer_count", 32'(dut.xfer_count), 32'(16'(model_count)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
